// File: rtl/io_periph_pkg.sv
// Shared definitions for the memory-mapped peripheral bank: window offsets,
// the decoded-window enum and the per-byte store-merge helper.
package io_periph_pkg;

  // Byte offsets of each window inside the peripheral address space.
  localparam int OUT_BASE = 'h000;
  localparam int SET_BASE = 'h100;
  localparam int CLR_BASE = 'h200;
  localparam int TGL_BASE = 'h300;
  localparam int IN_BASE  = 'h400;

  typedef enum logic [2:0] {
    WIN_OUT,
    WIN_SET,
    WIN_CLR,
    WIN_TGL,
    WIN_IN,
    WIN_NONE
  } io_win_e;

  // New value of one byte of an output register for a store through window
  // `win`; a disabled byte (or a non-output window) keeps its current value.
  function automatic logic [7:0] merge_byte(io_win_e win, logic [7:0] cur,
                                            logic [7:0] wd, logic en);
    logic [7:0] res;
    res = cur;
    if (en) begin
      case (win)
        WIN_OUT: res = wd;
        WIN_SET: res = cur | wd;
        WIN_CLR: res = cur & ~wd;
        WIN_TGL: res = cur ^ wd;
        default: res = cur;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One input word: two-flop synchroniser followed, when IO_DEBOUNCE_EN is
// defined, by a candidate register and a stability counter that only accepts
// a value after DEBOUNCE_CYCLES consecutive stable cycles. Without the macro
// the synchronised value is passed straight through.
module io_debounce
  import io_periph_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] in_i,
  output logic [DATA_W-1:0] deb_o
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("io_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [DATA_W-1:0] sync1_q, sync1_d;
  logic [DATA_W-1:0] sync2_q, sync2_d;

  // Synchroniser stages simply shift the raw input along.
  always_comb begin
    sync1_d = in_i;
    sync2_d = sync1_q;
  end

`ifdef IO_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] cand_q, cand_d;
  logic [DATA_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Count consecutive cycles where the synchronised value is stable and
  // differs from the accepted one; the count stops at CNT_LAST so it never wraps.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cand_d = sync2_q;
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync2_q == cand_q && sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers for the synchroniser and debounce filter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;
`else
  // Synchroniser registers only; the filter is bypassed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign deb_o = sync2_q;
`endif

endmodule

// File: rtl/io_periph_bank.sv
// Memory-mapped bank of NUM_OUT output registers (with set/clear/toggle
// aliases and byte enables) and NUM_IN synchronised input words behind a
// single load/store port. Loads are registered with a valid strobe; unmapped
// accesses raise a one-cycle error strobe. Optional input debouncing is
// enabled by defining IO_DEBOUNCE_EN.
module io_periph_bank
  import io_periph_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int NUM_OUT         = 11,
  parameter int NUM_IN          = 1,
  parameter int ADDR_W          = 12,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic                      ld_en_i,
  input  logic                      st_en_i,
  input  logic [DATA_W/8-1:0]       be_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      rvalid_o,
  output logic                      err_o,
  input  logic [NUM_IN*DATA_W-1:0]  io_in_i,
  output logic [NUM_OUT*DATA_W-1:0] io_out_o
);

  localparam int NB = DATA_W / 8;

  if ((DATA_W % 8) != 0 || NUM_OUT < 1 || NUM_OUT > 64 ||
      NUM_IN < 1 || NUM_IN > 64 || ADDR_W < 11) begin : g_bad_cfg
    $error("io_periph_bank: unsupported parameter set");
  end

  logic [DATA_W-1:0] out_q [NUM_OUT];
  logic [DATA_W-1:0] out_d [NUM_OUT];
  logic [DATA_W-1:0] in_word [NUM_IN];
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_val;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [31:0]       off32;
  logic [5:0]        idx;
  io_win_e           win;
  logic              st_act, st_ok, ld_ok;

  // Decode the word-aligned offset into a window and register index. Every
  // window spans 0x100 bytes, so the index is always offset bits [7:2].
  always_comb begin
    off32 = 32'(addr_i) & ~32'h3;
    idx   = off32[7:2];
    win   = WIN_NONE;
    if (off32 < IN_BASE) begin
      if (32'(idx) < NUM_OUT) begin
        if (off32 >= TGL_BASE)      win = WIN_TGL;
        else if (off32 >= CLR_BASE) win = WIN_CLR;
        else if (off32 >= SET_BASE) win = WIN_SET;
        else                        win = WIN_OUT;
      end
    end else if ((off32 - IN_BASE) < 32'(4 * NUM_IN)) begin
      win = WIN_IN;
    end
  end

  // A store with no enabled bytes is a no-op and never flags an error.
  always_comb begin
    st_act = st_en_i && (be_i != '0);
    st_ok  = (win == WIN_OUT) || (win == WIN_SET) ||
             (win == WIN_CLR) || (win == WIN_TGL);
    ld_ok  = (win != WIN_NONE);
  end

  // Next output-register contents: only the addressed register changes.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      out_d[i] = out_q[i];
      if (st_act && st_ok && idx == 6'(i)) begin
        for (int b = 0; b < NB; b++) begin
          out_d[i][8*b +: 8] = merge_byte(win, out_q[i][8*b +: 8],
                                          wdata_i[8*b +: 8], be_i[b]);
        end
      end
    end
  end

  // Load data uses pre-store register values; unmapped loads return 0 and
  // rdata holds its last value between loads.
  always_comb begin
    rd_val = '0;
    if (win == WIN_IN) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (idx == 6'(j)) rd_val = in_word[j];
      end
    end else if (ld_ok) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (idx == 6'(i)) rd_val = out_q[i];
      end
    end
    rdata_d  = ld_en_i ? rd_val : rdata_q;
    rvalid_d = ld_en_i;
    err_d    = (ld_en_i && !ld_ok) || (st_act && !st_ok);
  end

  // Bank state registers.
  // NOTE: the output registers are a small flop array, not a RAM, so they are
  // cleared by reset like any other state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= out_d[i];
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    io_debounce #(
      .DATA_W          (DATA_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .in_i  (io_in_i[g*DATA_W +: DATA_W]),
      .deb_o (in_word[g])
    );
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign io_out_o[g*DATA_W +: DATA_W] = out_q[g];
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule
